cordic_vec_atan2_16bit: RTL and testbench

- Iterative vectoring-mode CORDIC. Inverse of the rotation-mode trig unit: takes a signed 2-D vector (x, y) and returns its angle atan2(y, x) and its magnitude.
- Angle uses the same 16-bit binary-angle format as the trig unit: 0x10000 = 360°, so results round-trip with it.
- Same start/ready/done handshake as the trig unit; sits beside it in the DSP/trig cluster.

---
 rtl/cordic_vec_atan2_16bit.sv | 171 +++++++++++++++++
 tb/tb_cordic_vec_atan2_16bit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vec_atan2_16bit.sv
// Iterative vectoring-mode CORDIC: angle = atan2(y, x), magnitude = |(x, y)|.
// Angle is a 16-bit binary angle (0x10000 = 360 deg); start/ready/done handshake.
// Ports: clk, rst (async, active-high), start, x_in/y_in (signed 16),
//        angle (16), magnitude (17), done (1-cycle pulse), ready (IDLE only).
// Optional: CORDIC_GAIN_COMP_EN adds a COMP cycle that removes the CORDIC gain
//           from magnitude; without it magnitude is the raw K*r value.
module cordic_vec_atan2_16bit #(
    parameter int ITERATIONS = 16,
    parameter int GUARD      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic        [15:0] angle,
    output logic        [16:0] magnitude,
    output logic               done,
    output logic               ready
);

    // 3 integer growth bits keep K*sqrt(2)*32768 in range
    localparam int W = 19 + GUARD;

`ifdef CORDIC_GAIN_COMP_EN
    typedef enum logic [2:0] {IDLE, PRE, ITER, COMP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, PRE, ITER, DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] y_q, y_d;
    logic        [15:0]  z_q, z_d;
    logic        [3:0]   iter_q, iter_d;
    logic                zero_q, zero_d;
    logic        [15:0]  angle_q, angle_d;
    logic        [16:0]  mag_q, mag_d;
    logic                done_q, done_d;

    logic signed [W-1:0] xs, ys;

    function automatic logic [15:0] atan_lut(input logic [3:0] i);
        logic [15:0] a;
        case (i)
            4'd0:    a = 16'd8192;
            4'd1:    a = 16'd4836;
            4'd2:    a = 16'd2555;
            4'd3:    a = 16'd1297;
            4'd4:    a = 16'd651;
            4'd5:    a = 16'd326;
            4'd6:    a = 16'd163;
            4'd7:    a = 16'd81;
            4'd8:    a = 16'd41;
            4'd9:    a = 16'd20;
            4'd10:   a = 16'd10;
            4'd11:   a = 16'd5;
            4'd12:   a = 16'd3;
            4'd13:   a = 16'd1;
            4'd14:   a = 16'd1;
            default: a = 16'd0;
        endcase
        return a;
    endfunction

    assign xs = x_q >>> iter_q;
    assign ys = y_q >>> iter_q;

`ifdef CORDIC_GAIN_COMP_EN
    // 1/K = 0.607253 in Q15, rounded before the shift back
    logic signed [W+15:0] prod, prod_r;
    assign prod   = x_q * $signed({1'b0, 15'h4DBA});
    assign prod_r = prod + (W+16)'(16384);
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = W'(x_in) <<< GUARD;
                    y_d     = W'(y_in) <<< GUARD;
                    state_d = PRE;
                end
            end
            PRE: begin
                // fold left half-plane onto the right by a 180 deg turn
                if (x_q[W-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = 16'h8000;
                end else begin
                    z_d = 16'h0000;
                end
                zero_d  = (x_q == '0) && (y_q == '0);
                iter_d  = 4'd0;
                state_d = ITER;
            end
            ITER: begin
                if (!y_q[W-1]) begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + atan_lut(iter_q);
                end else begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - atan_lut(iter_q);
                end
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'(ITERATIONS - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = COMP;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
                x_d     = W'(prod_r >>> 15);
                state_d = DONE;
            end
`endif
            DONE: begin
                angle_d = zero_q ? 16'h0000 : z_q;
                mag_d   = zero_q ? 17'd0 : x_q[GUARD +: 17];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
            done_q  <= done_d;
        end
    end

    assign angle     = angle_q;
    assign magnitude = mag_q;
    assign done      = done_q;
    assign ready     = (state_q == IDLE);

endmodule

// File: tb/tb_cordic_vec_atan2_16bit.sv
// Bench for cordic_vec_atan2_16bit: directed vector table plus handshake
// and mid-operation reset sequences.
module tb_cordic_vec_atan2_16bit;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 18;
`endif

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic        [15:0] angle;
    logic        [16:0] magnitude;
    logic               done;
    logic               ready;

    int n_pass;
    int n_total;

    cordic_vec_atan2_16bit #(.ITERATIONS(16), .GUARD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle     (angle),
        .magnitude (magnitude),
        .done      (done),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic        [15:0] ang;
        int                 atol;
        int                 mag;
        int                 mtol;
    } vec_t;

    vec_t tv[8];

    task automatic check(input string nm, input bit ok, input int act, input int req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    endtask

    function automatic int adist(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        int sd;
        d  = a - b;
        sd = int'($signed(d));
        return (sd < 0) ? -sd : sd;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic wait_ready;
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready timeout", 1'b0, 0, 1);
    endtask

    // call at a negedge with ready=1; edge N is the next posedge
    task automatic run_vec(input logic signed [15:0] x, input logic signed [15:0] y,
                           output logic [15:0] ang, output int mag,
                           output int lat, output int width);
        x_in  = x;
        y_in  = y;
        start = 1'b1;
        lat   = -1;
        width = 0;
        ang   = '0;
        mag   = 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                width++;
                if (lat < 0) begin
                    lat = k;
                    ang = angle;
                    mag = int'(magnitude);
                end
            end
        end
    endtask

    logic [15:0] r_ang;
    int          r_mag, r_lat, r_w;
    int          pulses, p1, p2;
    logic [15:0] a1, a2;

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        start   = 1'b0;
        x_in    = '0;
        y_in    = '0;

`ifdef CORDIC_GAIN_COMP_EN
        tv[0] = '{16'sd16384, 16'sd0, 16'h0000, 3, 16384, 2};
        tv[1] = '{16'sd0, 16'sd16384, 16'h4000, 3, 16384, 2};
        tv[2] = '{-16'sd16384, 16'sd0, 16'h8000, 3, 16384, 2};
        tv[3] = '{16'sd0, -16'sd16384, 16'hC000, 3, 16384, 2};
        tv[4] = '{16'sd10000, -16'sd10000, 16'hE000, 3, 14142, 2};
        tv[5] = '{-16'sd32768, -16'sd32768, 16'hA000, 3, 46341, 2};
        tv[6] = '{16'sd0, 16'sd0, 16'h0000, 0, 0, 0};
        tv[7] = '{16'sd3000, 16'sd4000, 16'h25C8, 3, 5000, 2};
`else
        tv[0] = '{16'sd16384, 16'sd0, 16'h0000, 3, 26980, 3};
        tv[1] = '{16'sd0, 16'sd16384, 16'h4000, 3, 26980, 3};
        tv[2] = '{-16'sd16384, 16'sd0, 16'h8000, 3, 26980, 3};
        tv[3] = '{16'sd0, -16'sd16384, 16'hC000, 3, 26980, 3};
        tv[4] = '{16'sd10000, -16'sd10000, 16'hE000, 3, 23289, 3};
        tv[5] = '{-16'sd32768, -16'sd32768, 16'hA000, 3, 76312, 3};
        tv[6] = '{16'sd0, 16'sd0, 16'h0000, 0, 0, 0};
        tv[7] = '{16'sd3000, 16'sd4000, 16'h25C8, 3, 8234, 3};
`endif

        repeat (2) @(negedge clk);
        check("reset angle", angle == 16'h0000, int'(angle), 0);
        check("reset magnitude", magnitude == 17'd0, int'(magnitude), 0);
        check("reset done", done == 1'b0, int'(done), 0);
        check("reset ready", ready == 1'b1, int'(ready), 1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            wait_ready();
            run_vec(tv[i].x, tv[i].y, r_ang, r_mag, r_lat, r_w);
            check($sformatf("vec%0d latency", i), r_lat == LAT, r_lat, LAT);
            check($sformatf("vec%0d done width", i), r_w == 1, r_w, 1);
            check($sformatf("vec%0d angle", i),
                  adist(r_ang, tv[i].ang) <= tv[i].atol, int'(r_ang), int'(tv[i].ang));
            check($sformatf("vec%0d magnitude", i),
                  iabs(r_mag - tv[i].mag) <= tv[i].mtol, r_mag, tv[i].mag);
        end

        // start held high: back-to-back operations, inputs changed mid-flight
        wait_ready();
        x_in   = 16'sd16384;
        y_in   = 16'sd0;
        start  = 1'b1;
        pulses = 0;
        p1     = -1;
        p2     = -1;
        a1     = '0;
        a2     = '0;
        @(posedge clk);
        @(negedge clk);
        x_in = 16'sd0;
        y_in = 16'sd16384;
        for (int k = 1; k <= 44; k++) begin
            @(posedge clk);
            #1;
            if (done && k <= 40) begin
                pulses++;
                if (p1 < 0) begin
                    p1 = k;
                    a1 = angle;
                end else if (p2 < 0) begin
                    p2 = k;
                    a2 = angle;
                end
            end
            if (k == 40) begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        check("held start pulse count", pulses == 2, pulses, 2);
        check("held start first done", p1 == LAT, p1, LAT);
        check("held start second done", p2 == 2 * LAT + 1, p2, 2 * LAT + 1);
        check("held start first angle", adist(a1, 16'h0000) <= 3, int'(a1), 0);
        check("held start second angle", adist(a2, 16'h4000) <= 3, int'(a2), 16384);

        // third operation is now mid-ITER; reset must clear at once
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst angle", angle == 16'h0000, int'(angle), 0);
        check("midrst magnitude", magnitude == 17'd0, int'(magnitude), 0);
        check("midrst done", done == 1'b0, int'(done), 0);
        check("midrst ready", ready == 1'b1, int'(ready), 1);
        @(negedge clk);
        rst = 1'b0;

        wait_ready();
        run_vec(16'sd0, 16'sd16384, r_ang, r_mag, r_lat, r_w);
        check("post-reset latency", r_lat == LAT, r_lat, LAT);
        check("post-reset angle", adist(r_ang, 16'h4000) <= 3, int'(r_ang), 16384);
        check("post-reset magnitude", iabs(r_mag - tv[1].mag) <= tv[1].mtol, r_mag, tv[1].mag);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
